image_overlay_writer: RTL and testbench

Avalon-MM slave that lets software write a 224x224 8-bit luma image into on-chip RAM and streams it back out as an overlay on the 640x480 VGA raster. It is the write-side counterpart of the capture path: software is the producer, the pixel pipeline is the consumer. It sits in the `clk` (100 MHz) domain; pixel coordinates arrive already synchronized from the VGA clock domain.

---
 rtl/image_overlay_writer.sv | 175 +++++++++++++++++
 tb/tb_image_overlay_writer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_overlay_writer.sv
// Avalon-MM writable 224x224 luma overlay RAM with background clear and VGA-raster readout.
// Optional build macro IMAGE_OVERLAY_PACK4_EN: each DATA access moves four pixels instead of one.
module image_overlay_writer #(
   parameter int unsigned WIDTH    = 224,
   parameter int unsigned HEIGHT   = 224,
   parameter int unsigned ORIGIN_X = 208,
   parameter int unsigned ORIGIN_Y = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [10:0] pix_x,
   input  logic [10:0] pix_y,
   input  logic        pix_valid,
   output logic [7:0]  ovl_y,
   output logic        ovl_hit,
   output logic        ovl_valid
);
   localparam int unsigned N  = WIDTH * HEIGHT;
   localparam int unsigned AW = $clog2(N);
   localparam int unsigned SW = AW + 1;
   localparam int unsigned CW = 11;
   localparam int unsigned IW = 17;
`ifdef IMAGE_OVERLAY_PACK4_EN
   localparam int unsigned STEP = 4;
`else
   localparam int unsigned STEP = 1;
`endif
   localparam logic [CW-1:0] X_LO = CW'(ORIGIN_X);
   localparam logic [CW-1:0] X_HI = CW'(ORIGIN_X + WIDTH);
   localparam logic [CW-1:0] Y_LO = CW'(ORIGIN_Y);
   localparam logic [CW-1:0] Y_HI = CW'(ORIGIN_Y + HEIGHT);
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   // Pixel address base+ofs, wrapped into [0, N).
   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input int unsigned ofs);
      logic [SW-1:0] sum;
      sum = SW'(base) + SW'(ofs);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      return AW'(sum);
   endfunction

   state_t        state;
   logic [AW-1:0] ptr;
   logic [AW-1:0] cnt;
   logic          en;
   logic          drop;
   logic          range_err;
   logic [7:0]    mem [N];

   logic          busy_c;
   logic          data_wr_c;
   logic          ptr_wr_c;
   logic          ctrl_wr_c;
   logic          stat_wr_c;
   logic [AW-1:0] lane_addr_c [STEP];
   logic [31:0]   rd_word_c;
   logic          in_box_c;
   logic          hit_c;
   logic [IW-1:0] dx_c;
   logic [IW-1:0] dy_c;
   logic [IW-1:0] idx_c;
   logic          unused_c;

   assign busy_c    = (state == CLEAR);
   assign data_wr_c = wr_en && (addr == 2'd0);
   assign ptr_wr_c  = wr_en && (addr == 2'd1);
   assign ctrl_wr_c = wr_en && (addr == 2'd2);
   assign stat_wr_c = wr_en && (addr == 2'd3);
   assign unused_c  = ^writedata[31:16];

   // Consecutive pixel addresses covered by one DATA access.
   always_comb begin
      for (int k = 0; k < int'(STEP); k++) lane_addr_c[k] = wrap_add(ptr, k);
   end

   always_comb begin
      rd_word_c = '0;
      for (int k = 0; k < int'(STEP); k++) rd_word_c[8*k +: 8] = mem[lane_addr_c[k]];
   end

   // Raster coordinate to overlay RAM index; index only meaningful when in_box_c.
   always_comb begin
      in_box_c = (pix_x >= X_LO) && (pix_x < X_HI) && (pix_y >= Y_LO) && (pix_y < Y_HI);
      dx_c     = IW'(pix_x - X_LO);
      dy_c     = IW'(pix_y - Y_LO);
      idx_c    = IW'(WIDTH) * dy_c + dx_c;
      hit_c    = en && in_box_c && !busy_c;
   end

   // RAM write port: clear engine and software DATA writes never coincide.
   always_ff @(posedge clk) begin
      if (busy_c) begin
         mem[cnt] <= '0;
      end else if (data_wr_c) begin
         for (int k = 0; k < int'(STEP); k++) mem[lane_addr_c[k]] <= writedata[8*k +: 8];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else if (rd_en) begin
         case (addr)
            2'd0:    readdata <= rd_word_c;
            2'd1:    readdata <= 32'(ptr);
            2'd2:    readdata <= {31'd0, en};
            default: readdata <= {29'd0, range_err, drop, busy_c};
         endcase
      end else begin
         readdata <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovl_valid <= 1'b0;
         ovl_hit   <= 1'b0;
         ovl_y     <= '0;
      end else begin
         ovl_valid <= pix_valid;
         ovl_hit   <= pix_valid && hit_c;
         ovl_y     <= (pix_valid && hit_c) ? mem[AW'(idx_c)] : 8'd0;
      end
   end

   // Register file and clear FSM; clear completion owns ptr on its final cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         ptr       <= '0;
         en        <= 1'b0;
         drop      <= 1'b0;
         range_err <= 1'b0;
      end else begin
         if (data_wr_c) begin
            if (busy_c) drop <= 1'b1;
            else        ptr  <= wrap_add(ptr, STEP);
         end
         if (ptr_wr_c) begin
            if (writedata[15:0] < 16'(N)) ptr       <= AW'(writedata[15:0]);
            else                          range_err <= 1'b1;
         end
         if (ctrl_wr_c) en <= writedata[0];
         if (stat_wr_c) begin
            if (writedata[1]) drop      <= 1'b0;
            if (writedata[2]) range_err <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (ctrl_wr_c && writedata[1]) begin
                  state <= CLEAR;
                  cnt   <= '0;
               end
            end
            CLEAR: begin
               if (cnt == LAST) begin
                  state <= IDLE;
                  ptr   <= '0;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_image_overlay_writer.sv
// Randomized + directed bench for image_overlay_writer against an array-based behavioural model.
module tb_image_overlay_writer;
   localparam int W  = 224;
   localparam int H  = 224;
   localparam int OX = 208;
   localparam int OY = 128;
   localparam int N  = W * H;
`ifdef IMAGE_OVERLAY_PACK4_EN
   localparam int STEP = 4;
`else
   localparam int STEP = 1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  addr;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [10:0] pix_x;
   logic [10:0] pix_y;
   logic        pix_valid;
   logic [7:0]  ovl_y;
   logic        ovl_hit;
   logic        ovl_valid;

   image_overlay_writer dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .rd_en     (rd_en),
      .wr_en     (wr_en),
      .writedata (writedata),
      .readdata  (readdata),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_valid (pix_valid),
      .ovl_y     (ovl_y),
      .ovl_hit   (ovl_hit),
      .ovl_valid (ovl_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Reference model state: pixel array with "known" flags (RAM is not reset).
   logic [7:0] mm [N];
   bit         kn [N];
   int         m_ptr;
   bit         m_en;
   bit         m_drop;
   bit         m_range;
   bit         clr_act;
   int         clr_edge;

   function automatic bit busy_at(input int k);
      return clr_act && (k > clr_edge) && (k <= clr_edge + N);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus driven at a falling edge; outputs checked at the next falling edge.
   task automatic op(input string tag, input bit r, input bit w, input logic [1:0] a,
                     input logic [31:0] wd, input bit pv, input int px, input int py);
      logic [31:0] exp_rd;
      logic [31:0] mask;
      logic [7:0]  exp_y;
      bit          busy, inbox, hit, y_known;
      int          k, idx, ad;
      rd_en = r; wr_en = w; addr = a; writedata = wd;
      pix_valid = pv; pix_x = 11'(px); pix_y = 11'(py);
      @(negedge clk);
      k = cyc;
      if (clr_act && k > clr_edge + N) begin
         for (int i = 0; i < N; i++) begin mm[i] = 8'd0; kn[i] = 1'b1; end
         m_ptr   = 0;
         clr_act = 1'b0;
      end
      busy   = busy_at(k);
      exp_rd = 32'd0;
      mask   = 32'hFFFF_FFFF;
      if (r) begin
         case (a)
            2'd0: begin
               mask = 32'd0;
               for (int j = 0; j < STEP; j++) begin
                  ad = (m_ptr + j) % N;
                  exp_rd[8*j +: 8] = mm[ad];
                  if (kn[ad]) mask[8*j +: 8] = 8'hFF;
               end
               for (int j = STEP; j < 4; j++) mask[8*j +: 8] = 8'hFF;
            end
            2'd1:    exp_rd = 32'(m_ptr);
            2'd2:    exp_rd = {31'd0, m_en};
            default: exp_rd = {29'd0, m_range, m_drop, busy};
         endcase
      end
      inbox   = (px >= OX) && (px < OX + W) && (py >= OY) && (py < OY + H);
      hit     = pv && m_en && inbox && !busy;
      idx     = hit ? (py - OY) * W + (px - OX) : 0;
      exp_y   = hit ? mm[idx] : 8'd0;
      y_known = !hit || kn[idx];
      if (w) begin
         case (a)
            2'd0: begin
               if (busy) m_drop = 1'b1;
               else begin
                  for (int j = 0; j < STEP; j++) begin
                     ad = (m_ptr + j) % N;
                     mm[ad] = wd[8*j +: 8];
                     kn[ad] = 1'b1;
                  end
                  m_ptr = (m_ptr + STEP) % N;
               end
            end
            2'd1: begin
               if (int'(wd[15:0]) < N) m_ptr = int'(wd[15:0]);
               else m_range = 1'b1;
            end
            2'd2: begin
               m_en = wd[0];
               if (wd[1] && !busy) begin clr_act = 1'b1; clr_edge = k; end
            end
            default: begin
               if (wd[1]) m_drop = 1'b0;
               if (wd[2]) m_range = 1'b0;
            end
         endcase
      end
      if (mask != 32'd0) check({tag, ":readdata"}, readdata & mask, exp_rd & mask);
      check({tag, ":ovl_valid"}, 32'(ovl_valid), 32'(pv));
      if (pv) begin
         check({tag, ":ovl_hit"}, 32'(ovl_hit), 32'(hit));
         if (y_known) check({tag, ":ovl_y"}, 32'(ovl_y), 32'(exp_y));
      end
      rd_en = 1'b0; wr_en = 1'b0; pix_valid = 1'b0;
   endtask

   initial begin
      int fall;
      int sel;
      reset = 1'b1; addr = 2'd0; rd_en = 1'b0; wr_en = 1'b0; writedata = 32'd0;
      pix_x = 11'd0; pix_y = 11'd0; pix_valid = 1'b0;
      for (int i = 0; i < N; i++) begin mm[i] = 8'd0; kn[i] = 1'b0; end
      m_ptr = 0; m_en = 1'b0; m_drop = 1'b0; m_range = 1'b0; clr_act = 1'b0; clr_edge = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_readdata", readdata, 32'd0);
      check("rst_ovl_valid", 32'(ovl_valid), 32'd0);
      check("rst_ovl_hit", 32'(ovl_hit), 32'd0);
      check("rst_ovl_y", 32'(ovl_y), 32'd0);
      reset = 1'b0;

      op("status0", 1, 0, 2'd3, 0, 0, 0, 0);
      op("idle_rd", 0, 0, 2'd0, 0, 0, 0, 0);
      op("ptr0", 1, 0, 2'd1, 0, 0, 0, 0);
      op("ctrl0", 1, 0, 2'd2, 0, 0, 0, 0);

      // Pointer wrap at the last pixel.
      op("ptr_last", 0, 1, 2'd1, 32'd50175, 0, 0, 0);
      op("data_ab", 0, 1, 2'd0, 32'hAB, 0, 0, 0);
      op("data_cd", 0, 1, 2'd0, 32'hCD, 0, 0, 0);
      op("ptr_wrap", 1, 0, 2'd1, 0, 0, 0, 0);
      op("ptr_last2", 0, 1, 2'd1, 32'd50175, 0, 0, 0);
      op("rd_last", 1, 0, 2'd0, 0, 0, 0, 0);
      op("ptr_zero", 0, 1, 2'd1, 32'd0, 0, 0, 0);
      op("rd_zero", 1, 0, 2'd0, 0, 0, 0, 0);
`ifdef IMAGE_OVERLAY_PACK4_EN
      op("p4_ptr", 0, 1, 2'd1, 32'd50174, 0, 0, 0);
      op("p4_wr", 0, 1, 2'd0, 32'h4433_2211, 0, 0, 0);
      op("p4_ptr_rd", 1, 0, 2'd1, 0, 0, 0, 0);
      op("p4_ptr2", 0, 1, 2'd1, 32'd50174, 0, 0, 0);
      op("p4_rd", 1, 0, 2'd0, 0, 0, 0, 0);
`endif

      // Display path and box edges.
      op("en_on", 0, 1, 2'd2, 32'd1, 0, 0, 0);
      op("ptr_0b", 0, 1, 2'd1, 32'd0, 0, 0, 0);
      op("data_5a", 0, 1, 2'd0, 32'h5A, 0, 0, 0);
      op("pix_tl", 0, 0, 2'd0, 0, 1, 208, 128);
      op("pix_left", 0, 0, 2'd0, 0, 1, 207, 128);
      op("pix_br", 0, 0, 2'd0, 0, 1, 431, 351);
      op("pix_right", 0, 0, 2'd0, 0, 1, 432, 128);
      op("pix_above", 0, 0, 2'd0, 0, 1, 208, 127);
      op("pix_below", 0, 0, 2'd0, 0, 1, 208, 352);
      op("ptr_0c", 0, 1, 2'd1, 32'd0, 0, 0, 0);
      op("wr_and_pix", 0, 1, 2'd0, 32'hE7, 1, 208, 128);
      op("pix_new", 0, 0, 2'd0, 0, 1, 208, 128);
      op("ptr_0d", 0, 1, 2'd1, 32'd0, 0, 0, 0);
      op("rd_wr_same", 1, 1, 2'd0, 32'h3C, 0, 0, 0);
      op("ptr_0e", 0, 1, 2'd1, 32'd0, 0, 0, 0);
      op("rd_after_rw", 1, 0, 2'd0, 0, 0, 0, 0);

      // Out-of-range pointer and sticky RANGE.
      op("ptr_bad", 0, 1, 2'd1, 32'd50176, 0, 0, 0);
      op("ptr_kept", 1, 0, 2'd1, 0, 0, 0, 0);
      op("st_range", 1, 0, 2'd3, 0, 0, 0, 0);
      op("st_clr_rng", 0, 1, 2'd3, 32'h4, 0, 0, 0);
      op("st_after", 1, 0, 2'd3, 0, 0, 0, 0);
      op("en_off", 0, 1, 2'd2, 32'd0, 0, 0, 0);
      op("pix_dis", 0, 0, 2'd0, 0, 1, 208, 128);

      // Background clear with a dropped DATA write and writes honored while busy.
      op("clr", 0, 1, 2'd2, 32'h3, 0, 0, 0);
      repeat (8) op("clr_wait", 0, 0, 2'd0, 0, 0, 0, 0);
      op("drop_wr", 0, 1, 2'd0, 32'h99, 0, 0, 0);
      op("st_busy", 1, 0, 2'd3, 0, 0, 0, 0);
      op("pix_busy", 0, 0, 2'd0, 0, 1, 300, 200);
      op("clr_again", 0, 1, 2'd2, 32'h3, 0, 0, 0);
      op("ptr_busy", 0, 1, 2'd1, 32'd123, 0, 0, 0);
      op("ptr_busy_rd", 1, 0, 2'd1, 0, 0, 0, 0);
      repeat (N - 40) op("clr_run", 0, 0, 2'd0, 0, 0, 0, 0);
      fall = -1;
      for (int i = 0; i < 100 && fall < 0; i++) begin
         op("poll", 1, 0, 2'd3, 0, 0, 0, 0);
         if (readdata[0] == 1'b0) fall = cyc;
      end
      check("busy_len", 32'(fall), 32'(clr_edge + N + 1));
      op("ptr_after_clr", 1, 0, 2'd1, 0, 0, 0, 0);
      op("st_drop", 1, 0, 2'd3, 0, 0, 0, 0);
      op("st_clr_drop", 0, 1, 2'd3, 32'h2, 0, 0, 0);
      for (int i = 0; i < 24; i++) begin
         op("spot_ptr", 0, 1, 2'd1, 32'($urandom_range(0, N - 1)), 0, 0, 0);
         op("spot_rd", 1, 0, 2'd0, 0, 0, 0, 0);
      end

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1: op("r_ptr", 0, 1, 2'd1,
                     ($urandom_range(0, 19) == 0) ? 32'($urandom_range(N, 65535))
                                                  : 32'($urandom_range(0, N - 1)), 0, 0, 0);
            2, 3: op("r_data", bit'($urandom_range(0, 1)), 1, 2'd0, $urandom, 0, 0, 0);
            4:    op("r_rd", 1, 0, 2'd0, 0, 0, 0, 0);
            5:    op("r_reg", 1, 0, 2'($urandom_range(1, 3)), 0, 0, 0, 0);
            6:    op("r_en", 0, 1, 2'd2, 32'($urandom_range(0, 1)), 0, 0, 0);
            7:    op("r_st", 0, 1, 2'd3, 32'($urandom_range(0, 7)), 0, 0, 0);
            default:
               op("r_pix", 0, bit'($urandom_range(0, 1)), 2'd0, $urandom, 1,
                  int'($urandom_range(OX - 3, OX + W + 2)), int'($urandom_range(OY - 3, OY + H + 2)));
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
